// File: rtl/mux_arbiter_2x1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_2x1_pkg
// Purpose  : Shared definitions for the 2:1 arbitrated mux: output-register
//            FSM state encoding and requester port indices.
// Contents : state_t (ST_EMPTY, ST_FULL), PORT0, PORT1
// Revision : 1.0 - initial release
// ============================================================================
package mux_arbiter_2x1_pkg;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,  // no word held in dout
    ST_FULL  = 1'b1   // dout holds an unconsumed word
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_2x1_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_2x1_if
// Purpose  : Requester / consumer bus of the 2:1 arbitrated mux.
// Signals  : req0/req1, din0/din1 - requester side (word pending, data)
//            gnt0/gnt1            - one-cycle capture pulses
//            sel                  - mux select in use this cycle
//            dout, dout_valid     - registered output word and its flag
//            dout_ready           - consumer accepts dout
// Modports : master - environment (drives requests and dout_ready)
//            slave  - arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface mux_arbiter_2x1_if #(
  parameter int N = 8
);
  logic         req0;
  logic         req1;
  logic [N-1:0] din0;
  logic [N-1:0] din1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  modport master (
    output req0, req1, din0, din1, dout_ready,
    input  gnt0, gnt1, sel, dout, dout_valid
  );

  modport slave (
    input  req0, req1, din0, din1, dout_ready,
    output gnt0, gnt1, sel, dout, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter_2x1_mux.sv
`default_nettype none
// ============================================================================
// Module   : genericMux2x1
// Purpose  : Plain N-bit 2:1 multiplexer (data path of the arbiter).
// Ports    : i_d0, i_d1 - data inputs
//            i_sel      - 0 selects i_d0, 1 selects i_d1
//            o_y        - selected data
// Revision : 1.0 - initial release
// ============================================================================
module genericMux2x1 #(
  parameter int N = 8
) (
  input  wire logic [N-1:0] i_d0,
  input  wire logic [N-1:0] i_d1,
  input  wire logic         i_sel,
  output logic      [N-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule
`default_nettype wire

// File: rtl/mux_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_2x1
// Purpose  : Arbitrates two requesters onto one registered output word with
//            valid/ready back-pressure. Grants are combinational pulses; the
//            granted word is captured into dout on the same clock edge.
// Ports    : clk    - clock, all state on rising edge
//            resetn - asynchronous active-low reset
//            bus    - mux_arbiter_2x1_if.slave (requests, data, grants, output)
// Config   : MUX_ARB_ROUND_ROBIN_EN defined  -> contention alternates ports,
//                                               port 0 first after reset
//            MUX_ARB_ROUND_ROBIN_EN undefined -> port 0 always wins contention
// Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter_2x1 #(
  parameter int N = 8
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  mux_arbiter_2x1_if.slave  bus
);
  import mux_arbiter_2x1_pkg::*;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_last;      // most recently granted port
  logic         r_granted;   // at least one grant since reset
  logic [N-1:0] r_dout;

  logic         w_cap;
  logic         w_any;
  logic         w_grant;
  logic         w_win;
  logic         w_sel;
  logic [N-1:0] w_mux;

  // Arbitration and next-state logic
  always_comb begin
    w_cap       = (r_state == ST_EMPTY) || bus.dout_ready;
    w_any       = bus.req0 || bus.req1;
    // Gating with resetn keeps both grants low for the whole reset assertion.
    w_grant     = w_cap && w_any && resetn;
    w_win       = PORT0;
    if (bus.req0 && bus.req1) begin
`ifdef MUX_ARB_ROUND_ROBIN_EN
      w_win = ~r_last;
`else
      w_win = PORT0;
`endif
    end else if (bus.req1) begin
      w_win = PORT1;
    end
    // Outside a grant, sel holds the last granted port; before any grant
    // it reads port 0 even though last resets to port 1.
    if (w_grant) begin
      w_sel = w_win;
    end else if (r_granted) begin
      w_sel = r_last;
    end else begin
      w_sel = PORT0;
    end
    w_state_nxt = r_state;
    if (w_cap) begin
      w_state_nxt = w_any ? ST_FULL : ST_EMPTY;
    end
  end

  genericMux2x1 #(.N(N)) u_mux (
    .i_d0  (bus.din0),
    .i_d1  (bus.din1),
    .i_sel (w_sel),
    .o_y   (w_mux)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_EMPTY;
      r_last    <= PORT1;
      r_granted <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_dout    <= w_mux;
        r_last    <= w_win;
        r_granted <= 1'b1;
      end
    end
  end

  assign bus.gnt0       = w_grant && (w_win == PORT0);
  assign bus.gnt1       = w_grant && (w_win == PORT1);
  assign bus.sel        = w_sel;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = (r_state == ST_FULL);

endmodule
`default_nettype wire
